// File: rtl/mem_access_sequencer.sv
// Initiator for the unified memory port: sequences fetch/load/store strobes, B/H/W/D sizing,
// extension and sub-word read-modify-write. Define MISALIGN_TRAP_EN to fault misaligned accesses.
module mem_access_sequencer #(
    parameter int unsigned MEM_SIZE = 12288
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_fetch,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_fault,
    output logic [63:0] rsp_rdata,
    output logic [31:0] rsp_instr,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IorD,
    output logic [63:0] pc_addr,
    output logic [63:0] data_addr,
    output logic [63:0] write_data,
    input  logic [31:0] instruction,
    input  logic [63:0] read_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_ST_RD,
        S_ST_WR,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic        r_fault;
    logic [63:0] r_rdata;
    logic [31:0] r_instr;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_iord;
    logic [63:0] r_pc_addr;
    logic [63:0] r_data_addr;
    logic [63:0] r_write_data;

    logic        w_accept;
    logic [3:0]  w_nbytes;
    logic [64:0] w_end_addr;
    logic        w_range_fault;
    logic        w_misalign;
    logic        w_fault;
    logic [63:0] w_addr_src;
    logic [63:0] w_merged;
    logic [63:0] w_load_ext;

    assign w_accept = (r_state == S_IDLE) && req_valid;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_nbytes = 4'd1;
        if (req_fetch) begin
            w_nbytes = 4'd4;
        end else begin
            case (req_size)
                2'd0:    w_nbytes = 4'd1;
                2'd1:    w_nbytes = 4'd2;
                2'd2:    w_nbytes = 4'd4;
                default: w_nbytes = 4'd8;
            endcase
        end
    end

    // One extra bit keeps the range check honest for addresses near 2^64.
    assign w_end_addr    = {1'b0, req_addr} + {61'b0, w_nbytes};
    assign w_range_fault = w_end_addr > 65'(MEM_SIZE);

`ifdef MISALIGN_TRAP_EN
    logic [2:0] w_align_mask;
    assign w_align_mask = w_nbytes[2:0] - 3'd1;
    assign w_misalign   = |(req_addr[2:0] & w_align_mask);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_fault = w_range_fault | w_misalign | (req_fetch & req_write);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_fault)                w_next_state = S_RESP;
                    else if (req_fetch)         w_next_state = S_FETCH;
                    else if (!req_write)        w_next_state = S_LOAD;
                    else if (req_size == 2'd3)  w_next_state = S_ST_WR;
                    else                        w_next_state = S_ST_RD;
                end
            end
            S_FETCH: w_next_state = S_RESP;
            S_LOAD:  w_next_state = S_RESP;
            S_ST_RD: w_next_state = S_ST_WR;
            S_ST_WR: w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_merged = r_wdata;
        case (r_size)
            2'd0:    w_merged = {read_data[63:8],  r_wdata[7:0]};
            2'd1:    w_merged = {read_data[63:16], r_wdata[15:0]};
            2'd2:    w_merged = {read_data[63:32], r_wdata[31:0]};
            default: w_merged = r_wdata;
        endcase
    end

    always_comb begin
        w_load_ext = read_data;
        case (r_size)
            2'd0: w_load_ext = r_unsigned ? {56'b0, read_data[7:0]}
                                          : {{56{read_data[7]}}, read_data[7:0]};
            2'd1: w_load_ext = r_unsigned ? {48'b0, read_data[15:0]}
                                          : {{48{read_data[15]}}, read_data[15:0]};
            2'd2: w_load_ext = r_unsigned ? {32'b0, read_data[31:0]}
                                          : {{32{read_data[31]}}, read_data[31:0]};
            default: w_load_ext = read_data;
        endcase
    end

    // The first memory state is entered straight from IDLE, before r_addr holds the request.
    assign w_addr_src = (r_state == S_IDLE) ? req_addr : r_addr;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    // Memory-side outputs are registered from the next state so they line up with the state itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_size       <= '0;
            r_unsigned   <= 1'b0;
            r_fault      <= 1'b0;
            r_rdata      <= '0;
            r_instr      <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_iord       <= 1'b0;
            r_pc_addr    <= '0;
            r_data_addr  <= '0;
            r_write_data <= '0;
        end else begin
            r_mem_read   <= (w_next_state == S_FETCH) || (w_next_state == S_LOAD) ||
                            (w_next_state == S_ST_RD);
            r_mem_write  <= (w_next_state == S_ST_WR);
            r_iord       <= (w_next_state == S_LOAD) || (w_next_state == S_ST_RD) ||
                            (w_next_state == S_ST_WR);
            r_pc_addr    <= (w_next_state == S_FETCH) ? w_addr_src : '0;
            r_data_addr  <= ((w_next_state == S_LOAD) || (w_next_state == S_ST_RD) ||
                             (w_next_state == S_ST_WR)) ? w_addr_src : '0;
            r_write_data <= (w_next_state != S_ST_WR) ? '0 :
                            (r_state == S_IDLE)       ? req_wdata : w_merged;
            if (w_accept) begin
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_fault    <= w_fault;
            end
            if (r_state == S_FETCH) r_instr <= instruction;
            if (r_state == S_LOAD)  r_rdata <= w_load_ext;
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign rsp_valid  = (r_state == S_RESP);
    assign rsp_fault  = r_fault;
    assign rsp_rdata  = r_rdata;
    assign rsp_instr  = r_instr;
    assign MemRead    = r_mem_read;
    assign MemWrite   = r_mem_write;
    assign IorD       = r_iord;
    assign pc_addr    = r_pc_addr;
    assign data_addr  = r_data_addr;
    assign write_data = r_write_data;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer: byte-array memory model, request table with a
// response scoreboard, plus a hand-written reset-abort sequence. Honours MISALIGN_TRAP_EN.
module tb_mem_access_sequencer;

    localparam int unsigned MEM_SIZE = 12288;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_fetch;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_fault;
    logic [63:0] rsp_rdata;
    logic [31:0] rsp_instr;
    logic        MemRead;
    logic        MemWrite;
    logic        IorD;
    logic [63:0] pc_addr;
    logic [63:0] data_addr;
    logic [63:0] write_data;
    logic [31:0] instruction;
    logic [63:0] read_data;

    mem_access_sequencer #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_fetch(req_fetch),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_fault(rsp_fault), .rsp_rdata(rsp_rdata),
        .rsp_instr(rsp_instr),
        .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
        .pc_addr(pc_addr), .data_addr(data_addr), .write_data(write_data),
        .instruction(instruction), .read_data(read_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Byte-addressable memory with a few guard bytes past the end for 8-byte reads.
    logic [7:0] mem [0:MEM_SIZE+7];

    always_comb begin
        read_data   = '0;
        instruction = '0;
        for (int k = 0; k < 8; k++)
            read_data[8*k +: 8] = (data_addr + 64'(k) < 64'(MEM_SIZE + 8)) ?
                                  mem[14'(data_addr + 64'(k))] : 8'h00;
        for (int k = 0; k < 4; k++)
            instruction[8*k +: 8] = (pc_addr + 64'(k) < 64'(MEM_SIZE + 8)) ?
                                    mem[14'(pc_addr + 64'(k))] : 8'h00;
    end

    initial begin
        for (int i = 0; i < MEM_SIZE + 8; i++) mem[i] = 8'h00;
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h00; mem[3] = 8'h00;
        for (int i = 0; i < 8; i++) mem[32'h1000 + i] = 8'(8'h11 * (i + 1));
        forever begin
            @(negedge clk);
            if (MemWrite)
                for (int k = 0; k < 8; k++)
                    if (data_addr + 64'(k) < 64'(MEM_SIZE + 8))
                        mem[14'(data_addr + 64'(k))] <= write_data[8*k +: 8];
        end
    end

    typedef struct {
        logic        fetch;
        logic        write;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        fault;
        logic [63:0] exp_data;
        logic [63:0] exp_wdata;
        int          acc_cyc;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic f, input logic w, input logic [1:0] s, input logic u,
                                input logic [63:0] a, input logic [63:0] wd, input logic flt,
                                input logic [63:0] ed, input logic [63:0] ewd);
        vec_t v;
        v.fetch = f; v.write = w; v.size = s; v.uns = u; v.addr = a; v.wdata = wd;
        v.fault = flt; v.exp_data = ed; v.exp_wdata = ewd; v.acc_cyc = 0;
        return v;
    endfunction

    function automatic int exp_lat(input vec_t v);
        if (v.fault) return 1;
        if (v.write && v.size != 2'd3) return 3;
        return 2;
    endfunction

    function automatic int exp_rd(input vec_t v);
        if (v.fault || (v.write && v.size == 2'd3)) return 0;
        return 1;
    endfunction

    function automatic int exp_wr(input vec_t v);
        return (!v.fault && v.write) ? 1 : 0;
    endfunction

    task automatic send(input vec_t v);
        vec_t e;
        int   waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            check("ready_timeout", 64'(req_ready), 64'd1);
            return;
        end
        req_valid    = 1'b1;
        req_fetch    = v.fetch;
        req_write    = v.write;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        e = v;
        e.acc_cyc = cyc;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        check("ready_low_busy", 64'(req_ready), 64'd0);
    endtask

    logic mon_en = 1'b0;
    int   both_err = 0;
    int   orphan_err = 0;
    int   idle_bus_err = 0;

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_fetch = 1'b0; req_write = 1'b0;
        req_size = 2'd0; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

        fork
            begin : monitor
                int rd_cnt = 0;
                int wr_cnt = 0;
                vec_t cur;
                forever begin
                    @(negedge clk);
                    if (mon_en) begin
                        if (MemRead && MemWrite) both_err++;
                        if (MemRead || MemWrite) begin
                            if (sb.size() == 0) begin
                                orphan_err++;
                            end else begin
                                cur = sb[0];
                                if (MemRead)  rd_cnt++;
                                if (MemWrite) wr_cnt++;
                                check("iord", 64'(IorD), 64'(!cur.fetch));
                                if (cur.fetch) begin
                                    check("pc_addr", pc_addr, cur.addr);
                                    check("data_addr_unused", data_addr, 64'd0);
                                end else begin
                                    check("data_addr", data_addr, cur.addr);
                                    check("pc_addr_unused", pc_addr, 64'd0);
                                end
                                if (MemWrite) check("write_data", write_data, cur.exp_wdata);
                            end
                        end else if (pc_addr != 0 || data_addr != 0 || write_data != 0 || IorD) begin
                            idle_bus_err++;
                        end
                        if (rsp_valid) begin
                            if (sb.size() == 0) begin
                                orphan_err++;
                            end else begin
                                cur = sb.pop_front();
                                check("latency", 64'(cyc - cur.acc_cyc), 64'(exp_lat(cur)));
                                check("rsp_fault", 64'(rsp_fault), 64'(cur.fault));
                                check("read_strobes", 64'(rd_cnt), 64'(exp_rd(cur)));
                                check("write_strobes", 64'(wr_cnt), 64'(exp_wr(cur)));
                                if (!cur.fault && cur.fetch)
                                    check("rsp_instr", 64'(rsp_instr), {32'b0, cur.exp_data[31:0]});
                                if (!cur.fault && !cur.fetch && !cur.write)
                                    check("rsp_rdata", rsp_rdata, cur.exp_data);
                            end
                            rd_cnt = 0;
                            wr_cnt = 0;
                        end
                    end
                end
            end
        join_none

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_fault", 64'(rsp_fault), 64'd0);
        check("rst_strobes", {61'b0, MemRead, MemWrite, IorD}, 64'd0);
        check("rst_addr", pc_addr | data_addr | write_data, 64'd0);
        check("rst_rsp_data", rsp_rdata | 64'(rsp_instr), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset during the read half of SB 0xAA @0x1000: no write may ever reach memory.
        req_valid = 1'b1; req_fetch = 1'b0; req_write = 1'b1; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 64'h1000; req_wdata = 64'hAA;
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_st_rd_read", 64'(MemRead), 64'd1);
        check("abort_st_rd_addr", data_addr, 64'h1000);
        #2 reset_n = 1'b0;
        #1;
        check("abort_strobes", {62'b0, MemRead, MemWrite}, 64'd0);
        check("abort_ready", 64'(req_ready), 64'd1);
        begin
            int wr_seen = 0;
            repeat (3) begin
                @(negedge clk);
                if (MemWrite) wr_seen++;
            end
            check("abort_no_write", 64'(wr_seen), 64'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        //                fetch write size uns addr                   wdata                  fault exp_data               exp_wdata
        vecs.push_back(mk(1'b0, 1'b0, 2'd3, 1'b0, 64'h1000,             64'h0,                 1'b0, 64'h8877665544332211, 64'h0));
        vecs.push_back(mk(1'b1, 1'b0, 2'd0, 1'b0, 64'h0,                64'h0,                 1'b0, 64'h00000513,         64'h0));
        vecs.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 64'h1007,             64'h0,                 1'b0, 64'hFFFFFFFFFFFFFF88, 64'h0));
        vecs.push_back(mk(1'b0, 1'b0, 2'd0, 1'b1, 64'h1007,             64'h0,                 1'b0, 64'h88,               64'h0));
        vecs.push_back(mk(1'b0, 1'b0, 2'd1, 1'b0, 64'h1006,             64'h0,                 1'b0, 64'hFFFFFFFFFFFF8877, 64'h0));
        vecs.push_back(mk(1'b0, 1'b0, 2'd1, 1'b1, 64'h1002,             64'h0,                 1'b0, 64'h4433,             64'h0));
        vecs.push_back(mk(1'b0, 1'b0, 2'd2, 1'b0, 64'h1004,             64'h0,                 1'b0, 64'hFFFFFFFF88776655, 64'h0));
        vecs.push_back(mk(1'b0, 1'b0, 2'd2, 1'b1, 64'h1000,             64'h0,                 1'b0, 64'h44332211,         64'h0));
`ifdef MISALIGN_TRAP_EN
        vecs.push_back(mk(1'b0, 1'b0, 2'd2, 1'b0, 64'h1001,             64'h0,                 1'b1, 64'h0,                64'h0));
`else
        vecs.push_back(mk(1'b0, 1'b0, 2'd2, 1'b0, 64'h1001,             64'h0,                 1'b0, 64'h0000000055443322, 64'h0));
`endif
        vecs.push_back(mk(1'b0, 1'b1, 2'd1, 1'b0, 64'h1002,             64'hFFFFFFFFFFFFBEEF,  1'b0, 64'h0,                64'h000088776655BEEF));
        vecs.push_back(mk(1'b0, 1'b0, 2'd3, 1'b0, 64'h1000,             64'h0,                 1'b0, 64'h88776655BEEF2211, 64'h0));
        vecs.push_back(mk(1'b0, 1'b1, 2'd0, 1'b0, 64'h1003,             64'hAB12,              1'b0, 64'h0,                64'h0000008877665512));
        vecs.push_back(mk(1'b0, 1'b0, 2'd3, 1'b0, 64'h1000,             64'h0,                 1'b0, 64'h8877665512EF2211, 64'h0));
        vecs.push_back(mk(1'b0, 1'b1, 2'd2, 1'b0, 64'h1008,             64'h11111111CAFEF00D,  1'b0, 64'h0,                64'h00000000CAFEF00D));
        vecs.push_back(mk(1'b0, 1'b0, 2'd2, 1'b1, 64'h1008,             64'h0,                 1'b0, 64'hCAFEF00D,         64'h0));
        vecs.push_back(mk(1'b0, 1'b0, 2'd2, 1'b0, 64'h1008,             64'h0,                 1'b0, 64'hFFFFFFFFCAFEF00D, 64'h0));
        vecs.push_back(mk(1'b0, 1'b1, 2'd3, 1'b0, 64'h1010,             64'h0123456789ABCDEF,  1'b0, 64'h0,                64'h0123456789ABCDEF));
        vecs.push_back(mk(1'b0, 1'b0, 2'd3, 1'b0, 64'h1010,             64'h0,                 1'b0, 64'h0123456789ABCDEF, 64'h0));
        vecs.push_back(mk(1'b0, 1'b0, 2'd3, 1'b0, 64'h2FFC,             64'h0,                 1'b1, 64'h0,                64'h0));
        vecs.push_back(mk(1'b0, 1'b0, 2'd3, 1'b0, 64'h2FF8,             64'h0,                 1'b0, 64'h0,                64'h0));
        vecs.push_back(mk(1'b0, 1'b0, 2'd0, 1'b1, 64'h2FFF,             64'h0,                 1'b0, 64'h0,                64'h0));
        vecs.push_back(mk(1'b0, 1'b0, 2'd1, 1'b0, 64'h2FFF,             64'h0,                 1'b1, 64'h0,                64'h0));
        vecs.push_back(mk(1'b0, 1'b1, 2'd3, 1'b0, 64'h2FF9,             64'h5A5A,              1'b1, 64'h0,                64'h0));
        vecs.push_back(mk(1'b1, 1'b1, 2'd2, 1'b0, 64'h0,                64'h0,                 1'b1, 64'h0,                64'h0));
        vecs.push_back(mk(1'b0, 1'b0, 2'd3, 1'b0, 64'hFFFFFFFFFFFFFFF8, 64'h0,                 1'b1, 64'h0,                64'h0));
        vecs.push_back(mk(1'b1, 1'b0, 2'd3, 1'b0, 64'h2FFC,             64'h0,                 1'b0, 64'h0,                64'h0));
        vecs.push_back(mk(1'b1, 1'b0, 2'd0, 1'b0, 64'h2FFD,             64'h0,                 1'b1, 64'h0,                64'h0));
        vecs.push_back(mk(1'b1, 1'b0, 2'd1, 1'b0, 64'h0,                64'h0,                 1'b0, 64'h00000513,         64'h0));

        foreach (vecs[i]) send(vecs[i]);

        begin
            int waited = 0;
            while (sb.size() != 0 && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            check("drain_pending", 64'(sb.size()), 64'd0);
        end
        check("strobe_overlap", 64'(both_err), 64'd0);
        check("orphan_activity", 64'(orphan_err), 64'd0);
        check("idle_bus_nonzero", 64'(idle_bus_err), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
